// File: rtl/digit_code_tx_if.sv
// Parallel-code request and serial/display response bundle for digit_code_tx.
// The master drives the code request; the slave (the transmitter) drives the line and the display.
interface digit_code_tx_if;
  logic       start;
  logic [7:0] code;
  logic       ser_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] hex;

  modport master (
    output start,
    output code,
    input  ser_out,
    input  busy,
    input  done,
    input  err,
    input  hex
  );

  modport slave (
    input  start,
    input  code,
    output ser_out,
    output busy,
    output done,
    output err,
    output hex
  );
endinterface

// File: rtl/digit_code_tx.sv
// Sends a two-digit BCD code as a UART-style frame (start, 8 data LSB first, stop)
// and shows the digit currently on the line on an active-low 7-segment display.
module digit_code_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  digit_code_tx_if.slave bus
);

  localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [6:0]  HEX_BLANK = 7'b1111111;
  localparam logic [2:0]  IDX_LAST  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      code_q, code_d;

  logic            ser_q, ser_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [6:0]      hex_q, hex_d;

  logic            code_ok_c;
  logic            cnt_wrap_c;
  logic [3:0]      digit_c;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is shown blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = HEX_BLANK;
    endcase
    return s;
  endfunction

  assign code_ok_c  = (bus.code[3:0] <= 4'd9) && (bus.code[7:4] <= 4'd9);
  assign cnt_wrap_c = (cnt_q == CNT_LAST);

  // State, counters, latched code and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hex_q   <= HEX_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hex_q   <= hex_d;
    end
  end

  // Next-state: each bit lasts DIV cycles; the bit index only moves on a counter wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && code_ok_c) begin
          code_d  = bus.code;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_wrap_c) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_wrap_c) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_wrap_c) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    ser_d   = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    hex_d   = HEX_BLANK;
    digit_c = idx_d[2] ? code_d[7:4] : code_d[3:0];
    case (state_d)
      S_START: begin
        ser_d  = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        ser_d  = code_d[idx_d];
        busy_d = 1'b1;
        hex_d  = seg7(digit_c);
      end
      S_STOP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        ser_d = 1'b1;
      end
    endcase
    if ((state_q == S_IDLE) && bus.start && !code_ok_c) begin
      err_d = 1'b1;
    end
  end

  assign bus.ser_out = ser_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.hex     = hex_q;

endmodule

// File: tb/tb_digit_code_tx.sv
// Scoreboard bench for digit_code_tx: DIV=4 and DIV=1 instances, directed frames,
// refused codes, mid-frame start/code changes, mid-frame reset and held start.
module tb_digit_code_tx;

  localparam logic [6:0]  BLANK    = 7'b1111111;
  localparam logic [10:0] IDLE_OUT = {1'b1, 1'b0, 1'b0, 1'b0, BLANK};

  logic clk;
  logic reset;

  digit_code_tx_if if4 ();
  digit_code_tx_if if1 ();

  digit_code_tx #(.DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  digit_code_tx #(.DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs {ser,busy,done,err,hex} while busy/done/err is high.
  logic [10:0] q4[$];
  logic [10:0] q1[$];
  // Expected $time (at the sampling negedge) of each busy rising edge.
  time         t4[$];
  time         t1[$];
  logic        prev_busy4 = 1'b0;
  logic        prev_busy1 = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_exp(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // Pushes the first lim cycles of a frame for code c into dut w's scoreboard.
  task automatic push_frame(input int w, input logic [7:0] c, input int div, input int lim);
    logic [10:0] tq[$];
    logic [6:0]  h;
    for (int i = 0; i < div; i++) tq.push_back({1'b0, 1'b1, 1'b0, 1'b0, BLANK});
    for (int b = 0; b < 8; b++) begin
      h = (b < 4) ? seg_exp(c[3:0]) : seg_exp(c[7:4]);
      for (int i = 0; i < div; i++) tq.push_back({c[b], 1'b1, 1'b0, 1'b0, h});
    end
    for (int i = 0; i < div; i++) tq.push_back({1'b1, 1'b1, 1'b0, 1'b0, BLANK});
    tq.push_back({1'b1, 1'b0, 1'b1, 1'b0, BLANK});
    for (int i = 0; i < lim && i < tq.size(); i++) begin
      if (w == 0) q4.push_back(tq[i]);
      else        q1.push_back(tq[i]);
    end
  endtask

  task automatic mon(input int w, input logic [10:0] obs);
    logic [10:0] exp;
    checks++;
    if (obs[9] | obs[8] | obs[7]) begin
      if ((w == 0) ? (q4.size() == 0) : (q1.size() == 0)) begin
        errors++;
        $display("FAIL dut_div%0d unexpected_output at %0t: got %b, required idle %b",
                 (w == 0) ? 4 : 1, $time, obs, IDLE_OUT);
      end else begin
        exp = (w == 0) ? q4.pop_front() : q1.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL dut_div%0d frame_cycle at %0t: got %b, required %b",
                   (w == 0) ? 4 : 1, $time, obs, exp);
        end
      end
    end else if (obs !== IDLE_OUT) begin
      errors++;
      $display("FAIL dut_div%0d idle_outputs at %0t: got %b, required %b",
               (w == 0) ? 4 : 1, $time, obs, IDLE_OUT);
    end
  endtask

  task automatic check_start_time(input int w);
    time exp;
    checks++;
    if ((w == 0) ? (t4.size() == 0) : (t1.size() == 0)) begin
      errors++;
      $display("FAIL dut_div%0d unexpected_frame_start at %0t", (w == 0) ? 4 : 1, $time);
    end else begin
      exp = (w == 0) ? t4.pop_front() : t1.pop_front();
      if ($time != exp) begin
        errors++;
        $display("FAIL dut_div%0d frame_start_time: got %0t, required %0t",
                 (w == 0) ? 4 : 1, $time, exp);
      end
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (if4.busy && !prev_busy4) check_start_time(0);
      if (if1.busy && !prev_busy1) check_start_time(1);
      mon(0, {if4.ser_out, if4.busy, if4.done, if4.err, if4.hex});
      mon(1, {if1.ser_out, if1.busy, if1.done, if1.err, if1.hex});
    end
    prev_busy4 = if4.busy;
    prev_busy1 = if1.busy;
  end

  // Waits (bounded) for every expectation to be consumed, then checks that they were.
  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q4.size() == 0 && q1.size() == 0 && t4.size() == 0 && t1.size() == 0) break;
    end
    checks++;
    if (q4.size() != 0 || q1.size() != 0 || t4.size() != 0 || t1.size() != 0) begin
      errors++;
      $display("FAIL %s drain: outstanding q4=%0d q1=%0d t4=%0d t1=%0d, required all 0",
               name, q4.size(), q1.size(), t4.size(), t1.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // One-cycle start pulse issued on a falling edge.
  task automatic send(input int w, input logic [7:0] c, input logic expect_frame,
                      input int lim);
    @(negedge clk);
    if (w == 0) begin
      if4.code  = c;
      if4.start = 1'b1;
    end else begin
      if1.code  = c;
      if1.start = 1'b1;
    end
    if (expect_frame) begin
      push_frame(w, c, (w == 0) ? 4 : 1, lim);
      if (w == 0) t4.push_back($time + 10);
      else        t1.push_back($time + 10);
    end else if (w == 0) begin
      q4.push_back({1'b1, 1'b0, 1'b0, 1'b1, BLANK});
    end else begin
      q1.push_back({1'b1, 1'b0, 1'b0, 1'b1, BLANK});
    end
    @(negedge clk);
    if (w == 0) if4.start = 1'b0;
    else        if1.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({if4.ser_out, if4.busy, if4.done, if4.err, if4.hex} !== IDLE_OUT) begin
      errors++;
      $display("FAIL %s div4: got %b, required %b", name,
               {if4.ser_out, if4.busy, if4.done, if4.err, if4.hex}, IDLE_OUT);
    end
    checks++;
    if ({if1.ser_out, if1.busy, if1.done, if1.err, if1.hex} !== IDLE_OUT) begin
      errors++;
      $display("FAIL %s div1: got %b, required %b", name,
               {if1.ser_out, if1.busy, if1.done, if1.err, if1.hex}, IDLE_OUT);
    end
  endtask

  initial begin
    reset     = 1'b1;
    if4.start = 1'b0;
    if4.code  = 8'h00;
    if1.start = 1'b0;
    if1.code  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame for 0x06.
    send(0, 8'h06, 1'b1, 1000);
    drain("frame_06");

    // Refused codes: low nibble invalid, then high nibble invalid; 0x99 boundary is legal.
    send(0, 8'h3A, 1'b0, 0);
    drain("err_3A");
    send(0, 8'hA0, 1'b0, 0);
    drain("err_A0");

    // Mid-frame code change and start pulse are ignored.
    send(0, 8'h99, 1'b1, 1000);
    repeat (10) @(negedge clk);
    if4.code  = 8'h00;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    drain("frame_99_ignore");
    repeat (5) @(negedge clk);

    // Reset at frame cycle 15 for 0x45.
    send(0, 8'h45, 1'b1, 15);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h12, 1'b1, 1000);
    drain("frame_12_after_reset");

    // Start held high: second frame starts 42 cycles after the first.
    @(negedge clk);
    if4.code  = 8'h27;
    if4.start = 1'b1;
    push_frame(0, 8'h27, 4, 1000);
    push_frame(0, 8'h27, 4, 1000);
    t4.push_back($time + 10);
    t4.push_back($time + 10 + 420);
    repeat (60) @(negedge clk);
    if4.start = 1'b0;
    drain("held_start_27");

    // DIV=1 instance.
    send(1, 8'h81, 1'b1, 1000);
    drain("div1_frame_81");
    send(1, 8'h59, 1'b1, 1000);
    drain("div1_frame_59");
    send(1, 8'h9B, 1'b0, 0);
    drain("div1_err_9B");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
